settings_bus_cmd_issuer: RTL and testbench
==========================================

Name: settings_bus_cmd_issuer

Overview:
Upstream feeder for the settings register bus. It accepts address/data write commands over a valid/ready handshake and buffers them in a small FIFO. It then replays them onto the settings bus (strobe/addr/data) as single-cycle strobes, with a programmable minimum idle gap between strobes. Its outputs connect directly to the strobe/addr/in inputs of any number of setting_reg instances decoding their own addresses.

Parameters:
AWIDTH, 8, settings bus address width
DWIDTH, 32, settings bus data width
FIFO_SIZE, 3, log2 of command FIFO depth (default depth 8; legal range 1..6)
GAP_CYCLES, 0, number of strobe-low cycles forced after every strobe (legal range 0..15)

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
cmd_addr  input  AWIDTH  address of offered command
cmd_data  input  DWIDTH  data of offered command
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept a command (= not full)
hold  input  1  when high, no new strobe is started
set_stb  output  1  settings bus strobe, one cycle per write
set_addr  output  AWIDTH  settings bus address
set_data  output  DWIDTH  settings bus data
occupancy  output  FIFO_SIZE+1  number of commands currently buffered
write_count  output  16  number of strobes issued, wraps modulo 2^16
busy  output  1  high when FIFO is non-empty or FSM is not in IDLE

Behaviour:
- Reset (synchronous, active-high):
  - set_stb=0, set_addr=0, set_data=0, occupancy=0, write_count=0, busy=0, cmd_ready=1 from the first edge after rst is sampled high.
  - FIFO contents are discarded.
  - Reset mid-gap or mid-burst aborts immediately; no strobe is issued in the cycle after the reset edge.
- Handshake:
  - Transfer occurs when cmd_valid & cmd_ready at a rising edge.
  - cmd_ready = !full, registered from occupancy only. It does not look ahead at a same-cycle pop, so a full FIFO refuses input even while popping.
  - cmd_addr/cmd_data may change freely when no transfer occurs.
- FIFO:
  - Occupancy changes by +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop.
  - Pop occurs only when occupancy>0.
  - Order is strictly preserved.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if occupancy>0 and !hold, pop the head, register it onto set_addr/set_data, set set_stb=1, and go to ISSUE. Otherwise stay in IDLE with set_stb=0.
  - ISSUE, GAP_CYCLES=0: if occupancy>0 and !hold, pop the next command and keep set_stb=1, giving back-to-back strobes at one per cycle. Otherwise set set_stb=0 and go to IDLE.
  - ISSUE, GAP_CYCLES>0: set set_stb=0, load gap counter with GAP_CYCLES-1, and go to GAP.
  - GAP: set_stb=0. Decrement the counter; at 0 go to IDLE. hold has no effect in GAP; it only gates strobe starts.
- Latency:
  - A command accepted at edge k into an empty FIFO with FSM in IDLE and hold=0 produces set_stb high from edge k+1 to edge k+2.
- Outputs:
  - set_stb is high for exactly one cycle per command.
  - set_addr/set_data are valid while set_stb=1 and hold their last value while set_stb=0.
  - write_count increments on every cycle with set_stb=1 and wraps 0xFFFF->0x0000.
- Hold asserted in the same cycle a pop would occur: no pop and no strobe. Hold released: the strobe starts at the next edge.
- Minimum strobe period is 1+GAP_CYCLES clocks.

Test Plan:
- Single write: push addr 0x34, data 0x00000002 at edge k -> set_stb=1 only during cycle k+1..k+2 with addr 0x34, data 0x2; write_count=1; busy=0 afterwards.
- Burst, GAP_CYCLES=0: push 8 commands back-to-back (addr 0..7, data 0x100+i) -> cmd_ready drops after 8th push only if the FIFO fills; 8 consecutive strobe cycles in order; write_count=8.
- Gap spacing, GAP_CYCLES=3: push 4 commands -> strobes exactly 4 clocks apart; set_stb never high in two adjacent cycles.
- Full FIFO, FIFO_SIZE=3, hold=1: push 9 commands -> first 8 accepted, occupancy=8, cmd_ready=0, 9th held off, no strobes. Release hold -> 9th accepted one cycle after first pop; all 9 issued in order.
- Reset mid-burst: 5 commands queued, rst after 2nd strobe -> no further strobes, occupancy=0, write_count=0, set_addr=0, set_data=0.
- Counter wrap: preload by issuing 65537 writes -> write_count=1.

Source files
------------

// File: rtl/settings_bus_cmd_issuer.sv
// Buffers address/data write commands in a small FIFO and replays them onto the
// settings bus as single-cycle strobes separated by at least GAP_CYCLES idle cycles.
module settings_bus_cmd_issuer #(
   parameter int AWIDTH     = 8,
   parameter int DWIDTH     = 32,
   parameter int FIFO_SIZE  = 3,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [DWIDTH-1:0] cmd_data,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              hold,
   output logic              set_stb,
   output logic [AWIDTH-1:0] set_addr,
   output logic [DWIDTH-1:0] set_data,
   output logic [FIFO_SIZE:0] occupancy,
   output logic [15:0]       write_count,
   output logic              busy
);

   localparam int DEPTH = 1 << FIFO_SIZE;
   localparam logic [FIFO_SIZE:0] FULL_LEVEL = (FIFO_SIZE+1)'(DEPTH);
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP
   } state_t;

   state_t state, state_nxt;
   logic [3:0] gap_cnt, gap_cnt_nxt;

   logic [AWIDTH-1:0] fifo_addr [DEPTH];
   logic [DWIDTH-1:0] fifo_data [DEPTH];
   logic [FIFO_SIZE-1:0] wr_ptr, rd_ptr;

   logic push;
   logic pop;
   logic can_start;

   // Ready depends only on the registered level, never on a same-cycle pop.
   assign cmd_ready = (occupancy != FULL_LEVEL);
   assign push      = cmd_valid && cmd_ready;
   assign can_start = (occupancy != '0) && !hold;
   assign busy      = (occupancy != '0) || (state != IDLE);

   always_comb begin
      // NOTE: defaults first so every path assigns each output and no latch is inferred.
      state_nxt   = state;
      gap_cnt_nxt = gap_cnt;
      pop         = 1'b0;
      unique case (state)
         IDLE: begin
            if (can_start) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (GAP_CYCLES == 0) begin
               if (can_start) begin
                  pop = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               state_nxt   = GAP;
               gap_cnt_nxt = GAP_LOAD;
            end
         end
         GAP: begin
            // The last gap cycle may launch the next strobe, so the period is exactly 1+GAP_CYCLES.
            if (gap_cnt != 4'd0) begin
               gap_cnt_nxt = gap_cnt - 4'd1;
            end else if (can_start) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         gap_cnt     <= 4'd0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occupancy   <= '0;
         set_stb     <= 1'b0;
         set_addr    <= '0;
         set_data    <= '0;
         write_count <= 16'd0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_cnt_nxt;
         set_stb <= pop;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            set_addr    <= fifo_addr[rd_ptr];
            set_data    <= fifo_data[rd_ptr];
            write_count <= write_count + 16'd1;
         end
         unique case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   // NOTE: payload storage is not reset; pointers and occupancy alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= cmd_addr;
         fifo_data[wr_ptr] <= cmd_data;
      end
   end

endmodule

// File: tb/tb_settings_bus_cmd_issuer.sv
// Directed bench for settings_bus_cmd_issuer: one instance with no gap, one with
// GAP_CYCLES=3, sharing clock, reset, hold and command payload.
module tb_settings_bus_cmd_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        cmd_valid;
   logic        g_valid;
   logic        hold;

   logic        cmd_ready, set_stb, busy;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [3:0]  occupancy;
   logic [15:0] write_count;

   logic        g_ready, g_stb, g_busy;
   logic [7:0]  g_addr;
   logic [31:0] g_data;
   logic [3:0]  g_occ;
   logic [15:0] g_wc;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   typedef struct {
      int          cyc;
      logic [7:0]  a;
      logic [31:0] d;
   } ev_t;

   ev_t stb_q[$];
   ev_t gstb_q[$];
   ev_t ev_m, ev_g;
   logic g_prev = 1'b0;
   int   g_adjacent = 0;

   settings_bus_cmd_issuer #(.AWIDTH(8), .DWIDTH(32), .FIFO_SIZE(3), .GAP_CYCLES(0)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .hold       (hold),
      .set_stb    (set_stb),
      .set_addr   (set_addr),
      .set_data   (set_data),
      .occupancy  (occupancy),
      .write_count(write_count),
      .busy       (busy)
   );

   settings_bus_cmd_issuer #(.AWIDTH(8), .DWIDTH(32), .FIFO_SIZE(3), .GAP_CYCLES(3)) u_gap (
      .clk        (clk),
      .rst        (rst),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .cmd_valid  (g_valid),
      .cmd_ready  (g_ready),
      .hold       (hold),
      .set_stb    (g_stb),
      .set_addr   (g_addr),
      .set_data   (g_data),
      .occupancy  (g_occ),
      .write_count(g_wc),
      .busy       (g_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ncyc <= ncyc + 1;

   // Strobe log, sampled mid-cycle; ncyc is the number of rising edges so far.
   always @(negedge clk) begin
      if (set_stb) begin
         ev_m.cyc = ncyc;
         ev_m.a   = set_addr;
         ev_m.d   = set_data;
         stb_q.push_back(ev_m);
      end
      if (g_stb) begin
         ev_g.cyc = ncyc;
         ev_g.a   = g_addr;
         ev_g.d   = g_data;
         gstb_q.push_back(ev_g);
         if (g_prev) g_adjacent <= g_adjacent + 1;
      end
      g_prev <= g_stb;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Offers one command to the selected instance and returns right after the transfer edge.
   task automatic push(input bit sel, input logic [7:0] a, input logic [31:0] d);
      int n;
      n = 0;
      cmd_addr = a;
      cmd_data = d;
      if (sel) g_valid = 1'b1;
      else     cmd_valid = 1'b1;
      while (!(sel ? g_ready : cmd_ready)) begin
         if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: ready never rose for addr 0x%0h", a);
            break;
         end
         tick();
         n++;
      end
      tick();
      cmd_valid = 1'b0;
      g_valid   = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, p0, h, seen, n;

      rst = 1'b1; cmd_valid = 1'b0; g_valid = 1'b0; hold = 1'b0;
      cmd_addr = 8'h00; cmd_data = 32'h0;
      repeat (3) tick();
      check("rst_stb",   set_stb,     1'b0);
      check("rst_addr",  set_addr,    8'h00);
      check("rst_data",  set_data,    32'h0);
      check("rst_occ",   occupancy,   4'd0);
      check("rst_wc",    write_count, 16'd0);
      check("rst_busy",  busy,        1'b0);
      check("rst_ready", cmd_ready,   1'b1);
      check("rst_g_ready", g_ready,   1'b1);
      rst = 1'b0;
      tick();

      // Single write: one strobe the cycle after the transfer edge.
      push(1'b0, 8'h34, 32'h0000_0002);
      p0 = ncyc;
      check("single_occ_k",  occupancy, 4'd1);
      check("single_stb_k",  set_stb,   1'b0);
      tick();
      check("single_stb",    set_stb,     1'b1);
      check("single_addr",   set_addr,    8'h34);
      check("single_data",   set_data,    32'h2);
      check("single_wc",     write_count, 16'd1);
      tick();
      check("single_stb_off", set_stb,  1'b0);
      check("single_busy",    busy,     1'b0);
      check("single_addr_hold", set_addr, 8'h34);
      check("single_count", stb_q.size(), 1);
      if (stb_q.size() > 0) check("single_cyc", stb_q[0].cyc, p0 + 1);

      // Back-to-back burst without gap.
      base = stb_q.size();
      p0 = 0;
      for (int i = 0; i < 8; i++) begin
         push(1'b0, 8'(i), 32'h100 + 32'(i));
         if (i == 0) p0 = ncyc;
      end
      repeat (5) tick();
      check("burst_count", stb_q.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < stb_q.size()) begin
            check($sformatf("burst_addr[%0d]", i), stb_q[base+i].a,   8'(i));
            check($sformatf("burst_data[%0d]", i), stb_q[base+i].d,   32'h100 + 32'(i));
            check($sformatf("burst_cyc[%0d]", i),  stb_q[base+i].cyc, p0 + 1 + i);
         end
      end
      check("burst_wc",    write_count, 16'd9);
      check("burst_ready", cmd_ready,   1'b1);
      check("burst_busy",  busy,        1'b0);

      // Gap spacing on the GAP_CYCLES=3 instance.
      hold = 1'b1;
      for (int i = 0; i < 4; i++) push(1'b1, 8'h50 + 8'(i), 32'hC0DE_0000 + 32'(i));
      check("gap_occ_held", g_occ,         4'd4);
      check("gap_none_held", gstb_q.size(), 0);
      hold = 1'b0;
      h = ncyc;
      repeat (20) tick();
      check("gap_count", gstb_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < gstb_q.size()) begin
            check($sformatf("gap_cyc[%0d]", i),  gstb_q[i].cyc, h + 1 + 4*i);
            check($sformatf("gap_addr[%0d]", i), gstb_q[i].a,   8'h50 + 8'(i));
            check($sformatf("gap_data[%0d]", i), gstb_q[i].d,   32'hC0DE_0000 + 32'(i));
         end
      end
      check("gap_adjacent", g_adjacent, 0);
      check("gap_wc",       g_wc,       16'd4);
      check("gap_busy",     g_busy,     1'b0);

      // Full FIFO under hold, then release.
      hold = 1'b1;
      base = stb_q.size();
      for (int i = 0; i < 8; i++) push(1'b0, 8'h40 + 8'(i), 32'hA000_0000 + 32'(i));
      check("full_occ",   occupancy, 4'd8);
      check("full_ready", cmd_ready, 1'b0);
      check("full_busy",  busy,      1'b1);
      cmd_addr = 8'h48; cmd_data = 32'hA000_0008; cmd_valid = 1'b1;
      repeat (3) tick();
      check("full_refused_occ", occupancy, 4'd8);
      check("full_no_stb", stb_q.size() - base, 0);
      hold = 1'b0;
      h = ncyc;
      tick();
      check("full_pop_occ",   occupancy, 4'd7);
      check("full_pop_ready", cmd_ready, 1'b1);
      tick();
      check("full_9th_accepted_occ", occupancy, 4'd7);
      cmd_valid = 1'b0;
      repeat (12) tick();
      check("full_count", stb_q.size() - base, 9);
      for (int i = 0; i < 9; i++) begin
         if (base + i < stb_q.size()) begin
            check($sformatf("full_addr[%0d]", i), stb_q[base+i].a,   8'h40 + 8'(i));
            check($sformatf("full_data[%0d]", i), stb_q[base+i].d,   32'hA000_0000 + 32'(i));
            check($sformatf("full_cyc[%0d]", i),  stb_q[base+i].cyc, h + 1 + i);
         end
      end
      check("full_wc",  write_count, 16'd18);
      check("full_occ_end", occupancy, 4'd0);

      // Reset in the middle of a burst.
      hold = 1'b1;
      base = stb_q.size();
      for (int i = 0; i < 5; i++) push(1'b0, 8'h60 + 8'(i), 32'hB000_0000 + 32'(i));
      hold = 1'b0;
      seen = 0;
      n = 0;
      while (seen < 2 && n < 50) begin
         tick();
         if (set_stb) seen++;
         n++;
      end
      check("rstmid_seen_two", seen, 2);
      rst = 1'b1;
      tick();
      check("rstmid_stb",   set_stb,     1'b0);
      check("rstmid_occ",   occupancy,   4'd0);
      check("rstmid_wc",    write_count, 16'd0);
      check("rstmid_addr",  set_addr,    8'h00);
      check("rstmid_data",  set_data,    32'h0);
      check("rstmid_busy",  busy,        1'b0);
      check("rstmid_ready", cmd_ready,   1'b1);
      tick();
      rst = 1'b0;
      repeat (10) tick();
      check("rstmid_count", stb_q.size() - base, 2);
      check("rstmid_occ_after", occupancy, 4'd0);

      // Counter wrap through 65537 writes.
      stb_q.delete();
      for (int i = 0; i < 65537; i++) begin
         push(1'b0, 8'(i), 32'(i));
         if (i == 65535) check("wrap_wc_ffff", write_count, 16'hFFFF);
         if (i == 65536) check("wrap_wc_zero", write_count, 16'h0000);
      end
      repeat (4) tick();
      check("wrap_wc",    write_count,  16'd1);
      check("wrap_count", stb_q.size(), 65537);
      check("wrap_busy",  busy,         1'b0);
      check("wrap_addr",  set_addr,     8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
